// File: rtl/uart_tx_parity.sv
// UART transmitter with even parity, clocked at 8x the baud rate.
// Frame on txd: start (0), DATA_BITS data bits LSB first, even parity bit,
// STOP_BITS stop bits (1). All outputs come straight from flops.
module uart_tx_parity #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 gl_reset,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 dLoad,
    output logic                 tx_ready,
    output logic                 dDone,
    output logic                 txd
);

    // Counters are sized with +1 so a width of at least one bit is guaranteed.
    localparam int TICK_W = $clog2(OVERSAMPLE + 1);
    localparam int BIT_W  = $clog2(((DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS) + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                 state_q,  state_d;
    logic [TICK_W-1:0]      tick_q,   tick_d;
    logic [BIT_W-1:0]       bit_q,    bit_d;
    logic [DATA_BITS-1:0]   shift_q,  shift_d;
    logic                   parity_q, parity_d;
    logic                   txd_q,    txd_d;
    logic                   ready_q,  ready_d;
    logic                   done_q,   done_d;

    logic                   boundary;
    logic [DATA_BITS-1:0]   shift_nxt;

    assign tx_ready = ready_q;
    assign dDone    = done_q;
    assign txd      = txd_q;

    // State register; reset forces the line high immediately, aborting any frame.
    always_ff @(posedge clk or posedge gl_reset) begin
        if (gl_reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            txd_q    <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            txd_q    <= txd_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: each bit lasts OVERSAMPLE ticks, bit changes happen on the last tick.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        txd_d     = txd_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        boundary  = (tick_q == TICK_LAST);
        shift_nxt = shift_q >> 1;

        // Counters advance only in active states and clear on every state change.
        if (state_q != IDLE) begin
            tick_d = boundary ? '0 : tick_q + TICK_ONE;
        end

        case (state_q)
            IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                // A load while busy never reaches here, so in-flight data is safe.
                if (dLoad && ready_q) begin
                    shift_d  = din;
                    parity_d = ^din;
                    txd_d    = 1'b0;
                    ready_d  = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (boundary) begin
                    txd_d   = shift_q[0];
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (boundary) begin
                    if (bit_q == DATA_LAST) begin
                        txd_d   = parity_q;
                        bit_d   = '0;
                        state_d = PARITY;
                    end else begin
                        shift_d = shift_nxt;
                        txd_d   = shift_nxt[0];
                        bit_d   = bit_q + BIT_ONE;
                    end
                end
            end
            PARITY: begin
                if (boundary) begin
                    txd_d   = 1'b1;
                    bit_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (boundary) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                ready_d = 1'b1;
                tick_d  = '0;
                bit_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_parity.sv
// Directed testbench for uart_tx_parity: frame shape, parity, back-to-back,
// ignored loads while busy, async reset, and a byte sweep through a receiver model.
module tb_uart_tx_parity;

    logic       clk = 1'b0;
    logic       gl_reset = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dLoad = 1'b0;
    logic       tx_ready;
    logic       dDone;
    logic       txd;

    int pass_cnt  = 0;
    int total_cnt = 0;

    uart_tx_parity #(
        .DATA_BITS (8),
        .OVERSAMPLE(8),
        .STOP_BITS (1)
    ) dut (
        .clk     (clk),
        .gl_reset(gl_reset),
        .din     (din),
        .dLoad   (dLoad),
        .tx_ready(tx_ready),
        .dDone   (dDone),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One rising edge, then return on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Send one frame and check txd/tx_ready/dDone on every cycle from the
    // accept edge (n=0) to the return to idle (n=88). Optionally pulse dLoad
    // with inj_d at cycle inj_n. Returns at n=88 with dLoad left as-is if hold.
    task automatic send_frame(input logic [7:0] d, input logic p, input bit hold,
                              input int inj_n, input logic [7:0] inj_d);
        logic exp_txd;
        int   idx;
        check($sformatf("pre_ready_%02h", d), tx_ready, 1);
        din   = d;
        dLoad = 1'b1;
        tick();
        if (!hold) dLoad = 1'b0;
        for (int n = 0; n <= 88; n++) begin
            idx = n / 8;
            if (n == 88 || idx == 10) exp_txd = 1'b1;
            else if (idx == 0)        exp_txd = 1'b0;
            else if (idx <= 8)        exp_txd = d[idx-1];
            else                      exp_txd = p;
            check($sformatf("txd_%02h_n%0d", d, n), txd, exp_txd);
            check($sformatf("ready_%02h_n%0d", d, n), tx_ready, (n == 88));
            check($sformatf("done_%02h_n%0d", d, n), dDone, (n == 88));
            if (inj_n >= 0 && n == inj_n) begin
                din   = inj_d;
                dLoad = 1'b1;
            end else if (inj_n >= 0 && n == inj_n + 1) begin
                dLoad = 1'b0;
            end
            if (n < 88) tick();
        end
    endtask

    // Receiver model: find the start bit, sample each bit mid-way, check parity.
    task automatic rx_frame(output logic [7:0] data, output logic perr,
                            output logic stop, output logic found);
        int   cnt;
        logic par;
        cnt   = 0;
        found = 1'b0;
        data  = 8'h00;
        perr  = 1'b1;
        stop  = 1'b0;
        while (txd !== 1'b0 && cnt < 200) begin
            tick();
            cnt++;
        end
        if (txd === 1'b0) begin
            found = 1'b1;
            repeat (4) tick();
            if (txd !== 1'b0) found = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (8) tick();
                data[i] = txd;
            end
            repeat (8) tick();
            par = txd;
            repeat (8) tick();
            stop = txd;
            perr = ^{data, par};
        end
    endtask

    task automatic wait_ready(input string tag);
        int cnt;
        cnt = 0;
        while (tx_ready !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        check(tag, tx_ready, 1);
    endtask

    logic [7:0] rx_data;
    logic       rx_perr, rx_stop, rx_found;

    initial begin
        // Asynchronous reset with no clock edge yet.
        #1 gl_reset = 1'b1;
        #1;
        check("rst_txd", txd, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_done", dDone, 0);
        @(negedge clk);
        repeat (3) tick();
        gl_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("idle_txd_%0d", i), txd, 1);
            check($sformatf("idle_ready_%0d", i), tx_ready, 1);
            check($sformatf("idle_done_%0d", i), dDone, 0);
        end

        // 0xA5: 1,0,1,0,0,1,0,1 LSB first, four ones -> parity 0.
        send_frame(8'hA5, 1'b0, 1'b0, -1, 8'h00);
        tick();
        check("a5_done_one_cycle", dDone, 0);
        check("a5_idle_txd", txd, 1);

        // 0x01 and 0x80: single one -> parity 1.
        send_frame(8'h01, 1'b1, 1'b0, -1, 8'h00);
        send_frame(8'h80, 1'b1, 1'b0, -1, 8'h00);
        tick();

        // dLoad held high: frames 89 cycles apart with one idle-high cycle.
        send_frame(8'h00, 1'b0, 1'b1, -1, 8'h00);
        send_frame(8'hFF, 1'b0, 1'b1, -1, 8'h00);
        dLoad = 1'b0;
        tick();
        check("b2b_stop_after_release", txd, 1);

        // 0x5A (four ones -> parity 0) with a 0x3C load pulse at cycle 20.
        send_frame(8'h5A, 1'b0, 1'b0, 20, 8'h3C);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("no_2nd_txd_%0d", i), txd, 1);
            check($sformatf("no_2nd_ready_%0d", i), tx_ready, 1);
            check($sformatf("no_2nd_done_%0d", i), dDone, 0);
        end

        // Full byte sweep through the receiver model.
        for (int b = 0; b < 256; b++) begin
            din   = 8'(b);
            dLoad = 1'b1;
            tick();
            dLoad = 1'b0;
            rx_frame(rx_data, rx_perr, rx_stop, rx_found);
            check($sformatf("lb_found_%02h", b), rx_found, 1);
            check($sformatf("lb_data_%02h", b), rx_data, b);
            check($sformatf("lb_perr_%02h", b), rx_perr, 0);
            check($sformatf("lb_stop_%02h", b), rx_stop, 1);
            wait_ready($sformatf("lb_ready_%02h", b));
        end

        // Reset during data bit 4 (cycles 40..47): line returns high at once.
        din   = 8'h96;
        dLoad = 1'b1;
        tick();
        dLoad = 1'b0;
        repeat (43) tick();
        check("midrst_pre_txd", txd, 1'b1);   // bit 4 of 0x96 is 1
        check("midrst_pre_ready", tx_ready, 0);
        #1 gl_reset = 1'b1;
        #1;
        check("midrst_txd", txd, 1);
        check("midrst_ready", tx_ready, 1);
        check("midrst_done", dDone, 0);
        @(negedge clk);
        gl_reset = 1'b0;
        tick();
        check("postrst_idle_txd", txd, 1);
        din   = 8'h69;
        dLoad = 1'b1;
        tick();
        dLoad = 1'b0;
        rx_frame(rx_data, rx_perr, rx_stop, rx_found);
        check("postrst_found", rx_found, 1);
        check("postrst_data", rx_data, 8'h69);
        check("postrst_perr", rx_perr, 0);
        check("postrst_stop", rx_stop, 1);
        wait_ready("postrst_ready");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
